// File: rtl/sign_class_arbiter.sv
// Four-requester round-robin arbiter. Each transaction classifies the winner's
// 16-bit operand as positive, negative or zero and takes exactly four cycles.
module sign_class_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] data,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic        positive_flag,
    output logic        negative_flag,
    output logic        zero_flag,
    output logic        busy,
    output logic [7:0]  txn_count
);
    typedef enum logic [1:0] {IDLE, LOAD, EVAL, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        winner_q, winner_d;
    logic [1:0]        last_q, last_d;
    logic [15:0]       operand_q, operand_d;
    logic              pos_q, pos_d;
    logic              neg_q, neg_d;
    logic              zero_q, zero_d;
    logic [7:0]        count_q, count_d;
    logic [3:0][15:0]  ops;
    logic [1:0]        rr_idx;
    logic [1:0]        rr_pick;
    logic              rr_found;

    assign ops = data;

    // Search starts just above the previous winner, so it ends up lowest priority.
    always_comb begin
        rr_idx   = '0;
        rr_pick  = last_q;
        rr_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_q + 2'(i);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        operand_d = operand_q;
        pos_d     = pos_q;
        neg_d     = neg_q;
        zero_d    = zero_q;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    winner_d = rr_pick;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                operand_d = ops[winner_q];
                state_d   = EVAL;
            end
            EVAL: begin
                neg_d   = operand_q[15];
                zero_d  = (operand_q == 16'h0000);
                pos_d   = !operand_q[15] && (operand_q != 16'h0000);
                state_d = RESP;
            end
            RESP: begin
                last_d  = winner_q;
                count_d = count_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            winner_q  <= 2'd0;
            last_q    <= 2'd3;
            operand_q <= 16'h0000;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            zero_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
            operand_q <= operand_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            zero_q    <= zero_d;
            count_q   <= count_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign gnt           = busy ? (4'b0001 << winner_q) : 4'b0000;
    assign ack           = (state_q == RESP) ? (4'b0001 << winner_q) : 4'b0000;
    assign positive_flag = pos_q;
    assign negative_flag = neg_q;
    assign zero_flag     = zero_q;
    assign txn_count     = count_q;
endmodule

// File: tb/tb_sign_class_arbiter.sv
// Directed and randomized checks for sign_class_arbiter; inputs change and
// outputs are sampled 1 time unit after each rising edge.
module tb_sign_class_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        positive_flag;
    logic        negative_flag;
    logic        zero_flag;
    logic        busy;
    logic [7:0]  txn_count;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_POS  = 3'b100;
    localparam logic [2:0] F_NEG  = 3'b010;
    localparam logic [2:0] F_ZERO = 3'b001;

    sign_class_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .ack(ack),
        .positive_flag(positive_flag), .negative_flag(negative_flag),
        .zero_flag(zero_flag), .busy(busy), .txn_count(txn_count)
    );

    assign flags = {positive_flag, negative_flag, zero_flag};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Runs one transaction from an IDLE cycle whose req is already driven.
    task automatic txn(input string tag, input logic [3:0] w, input logic [2:0] f,
                       input logic [3:0] req_after);
        tick;
        chk({tag, "_load_gnt"}, gnt, w);
        chk({tag, "_load_busy"}, busy, 1);
        tick;
        chk({tag, "_eval_gnt"}, gnt, w);
        chk({tag, "_eval_ack"}, ack, 0);
        tick;
        chk({tag, "_resp_ack"}, ack, w);
        chk({tag, "_resp_flags"}, flags, f);
        req = req_after;
        tick;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_gnt"}, gnt, 0);
    endtask

    function automatic logic [2:0] cls(input logic [15:0] v);
        if (v[15]) return F_NEG;
        if (v == 16'h0000) return F_ZERO;
        return F_POS;
    endfunction

    initial begin
        logic [3:0]       rq;
        logic [3:0][15:0] nd;
        logic [1:0]       last_m, cur_w, idx;
        logic [3:0]       exp_g;
        logic [15:0]      exp_op;
        bit               exp_g_pend, seen_resp, found;
        int               waitc [4];
        int               max_wait, oh_bad, flag_bad, busy_cnt, ack_cnt, rnd_txns;

        rst = 1'b1; req = 4'b0000; data = 64'h0;
        tick;
        tick;
        chk("rst_gnt", gnt, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", flags, 0);
        chk("rst_count", txn_count, 0);
        rst = 1'b0;

        // Reset during EVAL of requester 2 aborts the transaction.
        req  = 4'b0100;
        data = 64'h0000_8001_0000_0000;
        tick;
        chk("abort_load_gnt", gnt, 4'b0100);
        tick;
        chk("abort_eval_gnt", gnt, 4'b0100);
        chk("abort_eval_flags", flags, 0);
        rst = 1'b1;
        tick;
        chk("abort_busy", busy, 0);
        chk("abort_ack", ack, 0);
        chk("abort_gnt", gnt, 0);
        chk("abort_flags", flags, 0);
        chk("abort_count", txn_count, 0);
        rst = 1'b0;
        txn("retry", 4'b0100, F_NEG, 4'b0000);
        chk("retry_count", txn_count, 1);

        // Single positive operand from requester 0.
        do_reset;
        req  = 4'b0001;
        data = 64'h0000_0000_0000_0005;
        txn("basic", 4'b0001, F_POS, 4'b0000);
        chk("basic_count", txn_count, 1);

        // All four requesting: strict rotation starting at 0.
        do_reset;
        data = {16'hFFFF, 16'h7FFF, 16'h0000, 16'h8000};
        req  = 4'b1111;
        txn("rr0", 4'b0001, F_NEG,  4'b1111);
        txn("rr1", 4'b0010, F_ZERO, 4'b1111);
        txn("rr2", 4'b0100, F_POS,  4'b1111);
        txn("rr3", 4'b1000, F_NEG,  4'b1111);
        txn("rr0b", 4'b0001, F_NEG, 4'b0000);
        chk("rr_count", txn_count, 5);

        // req dropped in LOAD and data changed in EVAL must not matter.
        req  = 4'b0010;
        data = 64'h0;
        tick;
        chk("drop_load_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick;
        data = 64'h0000_0000_1234_0000;
        tick;
        chk("drop_resp_ack", ack, 4'b0010);
        chk("drop_resp_flags", flags, F_ZERO);
        tick;
        chk("drop_count", txn_count, 6);

        // 256 back-to-back transactions from requester 3.
        do_reset;
        data = 64'hC000_0000_0000_0000;
        req  = 4'b1000;
        busy_cnt = 0;
        ack_cnt  = 0;
        for (int k = 0; k < 256; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick;
                busy_cnt += int'(busy);
                ack_cnt  += int'(ack == 4'b1000);
                if (k == 255 && c == 2) req = 4'b0000;
            end
            if (k == 254) chk("wrap_pre_count", txn_count, 255);
        end
        chk("wrap_count", txn_count, 0);
        chk("wrap_acks", ack_cnt, 256);
        chk("wrap_busy", busy_cnt, 768);
        chk("wrap_flags", flags, F_NEG);

        // Randomized traffic against a round-robin reference.
        do_reset;
        rq = 4'b0000; last_m = 2'd3; cur_w = 2'd0; exp_g = 4'b0000; exp_op = 16'h0;
        exp_g_pend = 0; seen_resp = 0;
        max_wait = 0; oh_bad = 0; flag_bad = 0; rnd_txns = 0;
        for (int i = 0; i < 4; i++) waitc[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick;
            if ((gnt & (gnt - 4'd1)) != 4'd0) oh_bad++;
            if (seen_resp && (int'(positive_flag) + int'(negative_flag) + int'(zero_flag)) != 1)
                flag_bad++;
            nd = {$urandom, $urandom};
            if (exp_g_pend) begin
                chk("rnd_gnt", gnt, exp_g);
                exp_g_pend = 0;
                exp_op = nd[cur_w];
            end
            if (ack != 4'b0000) begin
                chk("rnd_ack", ack, 4'b0001 << cur_w);
                chk("rnd_flags", flags, cls(exp_op));
                seen_resp = 1;
                rnd_txns++;
                last_m = cur_w;
                for (int i = 0; i < 4; i++) begin
                    if (i != int'(cur_w) && rq[i]) begin
                        waitc[i]++;
                        if (waitc[i] > max_wait) max_wait = waitc[i];
                    end
                end
                rq[cur_w] = 1'b0;
                waitc[cur_w] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (!rq[i] && $urandom_range(0, 1) == 1) begin
                    rq[i] = 1'b1;
                    waitc[i] = 0;
                end
            end
            req  = rq;
            data = nd;
            if (!busy && rq != 4'b0000) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    idx = last_m + 2'(k);
                    if (!found && rq[idx]) begin
                        found = 1;
                        cur_w = idx;
                    end
                end
                exp_g = 4'b0001 << cur_w;
                exp_g_pend = 1;
            end
        end
        chk("rnd_onehot", oh_bad, 0);
        chk("rnd_oneflag", flag_bad, 0);
        chk("rnd_fair", (max_wait > 3), 0);
        chk("rnd_active", (rnd_txns > 50), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
